// File: rtl/scoreboard_hazard_unit.sv
// Register busy scoreboard for variable-latency units: stalls decode on RAW/WAW
// conflicts or a full outstanding-op window, with completion bypass and a stall watchdog.
module scoreboard_hazard_unit #(
  parameter int REG_AW    = 5,
  parameter int NUM_CMPL  = 2,
  parameter int MAX_OUTST = 4,
  parameter int TIMEOUT   = 1024,
  localparam int NUM_REGS = 2**REG_AW,
  localparam int OUT_W    = $clog2(MAX_OUTST+1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       d_valid,
  input  logic [REG_AW-1:0]          d_rs1,
  input  logic [REG_AW-1:0]          d_rs2,
  input  logic                       d_rs1_used,
  input  logic                       d_rs2_used,
  input  logic [REG_AW-1:0]          d_rd,
  input  logic                       d_rd_we,
  input  logic                       d_long,
  input  logic                       flush,
  input  logic [NUM_CMPL-1:0]        cmpl_valid,
  input  logic [NUM_CMPL*REG_AW-1:0] cmpl_rd,
  output logic                       stall_d,
  output logic [NUM_REGS-1:0]        busy_vec,
  output logic [OUT_W-1:0]           outstanding,
  output logic                       cmpl_err,
  output logic                       hazard_timeout
);

  localparam int WD_W = $clog2(TIMEOUT);

  logic [NUM_REGS-1:0] clr_vec;
  logic [NUM_REGS-1:0] eff_busy;
  logic [NUM_REGS-1:0] set_vec;
  logic [OUT_W-1:0]    clr_cnt;
  logic [OUT_W-1:0]    out_after;
  logic                cmpl_bad;
  logic                cmpl_dup;
  logic                raw;
  logic                waw;
  logic                cap;
  logic                rd_long;
  logic                fire;
  logic [WD_W-1:0]     wd_left;

  // Completions to x0 are ignored entirely; duplicates clear once but are flagged.
  always_comb begin
    clr_vec  = '0;
    cmpl_bad = 1'b0;
    cmpl_dup = 1'b0;
    for (int i = 0; i < NUM_CMPL; i++) begin
      if (cmpl_valid[i] && (cmpl_rd[i*REG_AW +: REG_AW] != '0)) begin
        if (busy_vec[cmpl_rd[i*REG_AW +: REG_AW]])
          clr_vec[cmpl_rd[i*REG_AW +: REG_AW]] = 1'b1;
        else
          cmpl_bad = 1'b1;
        for (int j = 0; j < i; j++) begin
          if (cmpl_valid[j] && (cmpl_rd[j*REG_AW +: REG_AW] == cmpl_rd[i*REG_AW +: REG_AW]))
            cmpl_dup = 1'b1;
        end
      end
    end
  end

  always_comb begin
    clr_cnt = '0;
    for (int r = 0; r < NUM_REGS; r++)
      clr_cnt = clr_cnt + OUT_W'(clr_vec[r]);
  end

  assign eff_busy  = busy_vec & ~clr_vec;
  assign out_after = outstanding - clr_cnt;
  assign rd_long   = d_long & d_rd_we & (d_rd != '0);

  assign raw = (d_rs1_used & (d_rs1 != '0) & eff_busy[d_rs1]) |
               (d_rs2_used & (d_rs2 != '0) & eff_busy[d_rs2]);
  assign waw = d_rd_we & (d_rd != '0) & eff_busy[d_rd];
  assign cap = rd_long & (out_after == OUT_W'(MAX_OUTST));

  // Gated by rst_n so the stall drops the moment reset is asserted.
  assign stall_d = rst_n & d_valid & ~flush & (raw | waw | cap);
  assign fire    = d_valid & ~flush & ~stall_d & rd_long;

  always_comb begin
    set_vec = '0;
    if (fire) set_vec[d_rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_vec    <= '0;
      outstanding <= '0;
      cmpl_err    <= 1'b0;
    end else begin
      busy_vec    <= eff_busy | set_vec;
      outstanding <= out_after + OUT_W'(fire);
      cmpl_err    <= cmpl_err | cmpl_bad | cmpl_dup;
    end
  end

  // Watchdog counts down the stall cycles remaining; reaching zero while still
  // stalled is the TIMEOUT-th consecutive stall, and the count then holds at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_left        <= WD_W'(TIMEOUT-1);
      hazard_timeout <= 1'b0;
    end else if (stall_d) begin
      if (wd_left == '0)
        hazard_timeout <= 1'b1;
      else
        wd_left <= wd_left - 1'b1;
    end else begin
      wd_left <= WD_W'(TIMEOUT-1);
    end
  end

endmodule

// File: tb/tb_scoreboard_hazard_unit.sv
// Randomized + directed bench for scoreboard_hazard_unit; a reference model pushes
// expected per-cycle outputs into a queue that a negedge monitor pops and checks.
module tb_scoreboard_hazard_unit;
  localparam int REG_AW = 5, NUM_CMPL = 2, MAX_OUTST = 4, TIMEOUT = 8;
  localparam int NR = 32, OW = $clog2(MAX_OUTST+1);

  logic clk = 1'b0, rst_n = 1'b0;
  logic d_valid = 0, d_rs1_used = 0, d_rs2_used = 0, d_rd_we = 0, d_long = 0, flush = 0;
  logic [4:0] d_rs1 = 0, d_rs2 = 0, d_rd = 0;
  logic [1:0] cmpl_valid = 0;
  logic [9:0] cmpl_rd = 0;
  logic stall_d, cmpl_err, hazard_timeout;
  logic [31:0] busy_vec;
  logic [OW-1:0] outstanding;

  scoreboard_hazard_unit #(.REG_AW(REG_AW), .NUM_CMPL(NUM_CMPL), .MAX_OUTST(MAX_OUTST),
                           .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .d_valid(d_valid), .d_rs1(d_rs1), .d_rs2(d_rs2),
    .d_rs1_used(d_rs1_used), .d_rs2_used(d_rs2_used), .d_rd(d_rd), .d_rd_we(d_rd_we),
    .d_long(d_long), .flush(flush), .cmpl_valid(cmpl_valid), .cmpl_rd(cmpl_rd),
    .stall_d(stall_d), .busy_vec(busy_vec), .outstanding(outstanding),
    .cmpl_err(cmpl_err), .hazard_timeout(hazard_timeout));

  always #5 clk = ~clk;

  typedef struct { bit stall; bit [31:0] busy; int outst; bit err; bit tmo; } exp_t;
  exp_t q[$];
  int errors = 0, checks = 0;

  // Reference model: a set of busy registers plus sticky flags and a stall run length.
  bit m_busy[NR];
  bit m_err, m_tmo;
  int m_run;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit [31:0] m_vec();
    bit [31:0] v = 0;
    for (int r = 0; r < NR; r++) v[r] = m_busy[r];
    return v;
  endfunction

  function automatic int m_count();
    int n = 0;
    for (int r = 0; r < NR; r++) n += int'(m_busy[r]);
    return n;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < NR; r++) m_busy[r] = 0;
    m_err = 0; m_tmo = 0; m_run = 0;
  endtask

  task automatic idle_inputs();
    d_valid = 0; d_rs1_used = 0; d_rs2_used = 0; d_rd_we = 0; d_long = 0; flush = 0;
    d_rs1 = 0; d_rs2 = 0; d_rd = 0; cmpl_valid = 0; cmpl_rd = 0;
  endtask

  task automatic step(input bit v, input bit [4:0] rs1, input bit u1, input bit [4:0] rs2,
                      input bit u2, input bit [4:0] rd, input bit we, input bit lg,
                      input bit fl, input bit [1:0] cv, input bit [4:0] c0, input bit [4:0] c1);
    bit clr[NR];
    bit [4:0] crd[2];
    bit e, raw, waw, cap, stall, fire;
    int nclr;
    exp_t x;
    @(posedge clk); #1;
    d_valid = v; d_rs1 = rs1; d_rs1_used = u1; d_rs2 = rs2; d_rs2_used = u2;
    d_rd = rd; d_rd_we = we; d_long = lg; flush = fl; cmpl_valid = cv; cmpl_rd = {c1, c0};
    crd[0] = c0; crd[1] = c1;
    e = 0; nclr = 0;
    for (int r = 0; r < NR; r++) clr[r] = 0;
    for (int c = 0; c < 2; c++)
      if (cv[c] && crd[c] != 0) begin
        if (m_busy[crd[c]]) clr[crd[c]] = 1; else e = 1;
      end
    if (cv == 2'b11 && c0 == c1 && c0 != 0) e = 1;
    for (int r = 0; r < NR; r++) nclr += int'(clr[r]);
    raw = (u1 && rs1 != 0 && m_busy[rs1] && !clr[rs1]) ||
          (u2 && rs2 != 0 && m_busy[rs2] && !clr[rs2]);
    waw = we && rd != 0 && m_busy[rd] && !clr[rd];
    cap = lg && we && rd != 0 && (m_count() - nclr == MAX_OUTST);
    stall = v && !fl && (raw || waw || cap);
    fire = v && !fl && !stall && lg && we && rd != 0;
    x.stall = stall; x.busy = m_vec(); x.outst = m_count(); x.err = m_err; x.tmo = m_tmo;
    q.push_back(x);
    for (int r = 0; r < NR; r++) if (clr[r]) m_busy[r] = 0;
    if (fire) m_busy[rd] = 1;
    m_err = m_err | e;
    m_run = stall ? m_run + 1 : 0;
    if (m_run >= TIMEOUT) m_tmo = 1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0,0,0,0,0,0,0,0,0,2'b00,0,0);
  endtask

  task automatic rand_step();
    int bl[$];
    bit [4:0] c[2];
    bit [1:0] cv;
    for (int r = 1; r < NR; r++) if (m_busy[r]) bl.push_back(r);
    for (int k = 0; k < 2; k++) begin
      if (bl.size() > 0 && $urandom_range(0, 9) < 8) c[k] = 5'(bl[$urandom_range(0, bl.size()-1)]);
      else c[k] = 5'($urandom_range(0, 9));
    end
    cv = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
    step($urandom_range(0, 9) < 8, 5'($urandom_range(0, 9)), 1'($urandom),
         5'($urandom_range(0, 9)), 1'($urandom), 5'($urandom_range(0, 9)),
         $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 6, $urandom_range(0, 9) == 0,
         cv, c[0], c[1]);
  endtask

  task automatic pulse_reset();
    @(negedge clk); #2;
    rst_n = 0;
    #1;
    chk("rst_stall", 32'(stall_d), 0);
    chk("rst_busy", busy_vec, 0);
    chk("rst_outst", 32'(outstanding), 0);
    chk("rst_err", 32'(cmpl_err), 0);
    chk("rst_tmo", 32'(hazard_timeout), 0);
    idle_inputs();
    model_reset();
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1;
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t x;
      x = q.pop_front();
      chk("stall_d", 32'(stall_d), 32'(x.stall));
      chk("busy_vec", busy_vec, x.busy);
      chk("outstanding", 32'(outstanding), 32'(x.outst));
      chk("cmpl_err", 32'(cmpl_err), 32'(x.err));
      chk("hazard_timeout", 32'(hazard_timeout), 32'(x.tmo));
    end
  end

  initial begin
    model_reset();
    idle_inputs();
    #23 rst_n = 1;
    // 1: idle after reset
    idle(3);
    // 2: long op to x5, RAW stall, bypass on channel 1
    step(1,0,0,0,0,5,1,1,0,2'b00,0,0);
    step(1,5,1,0,0,8,1,0,0,2'b00,0,0);
    step(1,5,1,0,0,8,1,0,0,2'b00,0,0);
    step(1,5,1,0,0,8,1,0,0,2'b10,0,5);
    idle(1);
    // 3: fill window, cap stall, then bypass frees a slot
    for (int r = 1; r <= 4; r++) step(1,0,0,0,0,5'(r),1,1,0,2'b00,0,0);
    step(1,0,0,0,0,6,1,1,0,2'b00,0,0);
    step(1,0,0,0,0,6,1,1,0,2'b00,0,0);
    step(1,0,0,0,0,6,1,1,0,2'b01,2,0);
    idle(1);
    step(0,0,0,0,0,0,0,0,0,2'b11,1,3);
    step(0,0,0,0,0,0,0,0,0,2'b11,4,6);
    // 4: x0 writes and completions are ignored; completion to idle x9 flags error
    step(1,0,0,0,0,0,1,1,0,2'b01,0,0);
    idle(1);
    step(0,0,0,0,0,0,0,0,0,2'b01,9,0);
    idle(2);
    // 5: flush hides a RAW and suppresses fire; duplicate completion clears once
    step(1,0,0,0,0,7,1,1,0,2'b00,0,0);
    step(1,7,1,0,0,10,1,1,1,2'b00,0,0);
    idle(1);
    step(0,0,0,0,0,0,0,0,0,2'b11,7,7);
    idle(1);
    pulse_reset();
    for (int i = 0; i < 400; i++) rand_step();
    pulse_reset();
    // 6: hold a RAW stall past the watchdog limit, then reset asynchronously
    step(1,0,0,0,0,3,1,1,0,2'b00,0,0);
    for (int i = 0; i < TIMEOUT + 2; i++) step(1,3,1,0,0,9,1,0,0,2'b00,0,0);
    pulse_reset();
    idle(1);
    for (int i = 0; i < 300; i++) rand_step();
    idle(2);
    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      errors++;
      checks++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/scoreboard_hazard_unit.md
Name: scoreboard_hazard_unit

Overview:
Parametrised successor to the single-cycle pipeline hazard logic, for a core with multiple variable-latency units (divider, multiplier, cache-miss loads).
- Keeps a per-register busy scoreboard for long-latency writes in flight.
- Stalls decode on RAW/WAW conflicts and enforces a cap on outstanding long ops.
- Accepts completions from NUM_CMPL write-back channels.
- Watches for stuck stalls with a watchdog.
- Sits beside the existing forwarding/flush logic and drives the decode-stage stall.

Parameters:
REG_AW, 5, register address width; NUM_REGS = 2**REG_AW
NUM_CMPL, 2, number of independent completion channels
MAX_OUTST, 4, maximum long ops in flight (1..NUM_REGS-1)
TIMEOUT, 1024, consecutive stall cycles before watchdog fires (>=2)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
d_valid  in  1  decode stage holds a valid instruction
d_rs1  in  REG_AW  source 1 address
d_rs2  in  REG_AW  source 2 address
d_rs1_used  in  1  rs1 is read by this opcode
d_rs2_used  in  1  rs2 is read by this opcode
d_rd  in  REG_AW  destination address
d_rd_we  in  1  instruction writes rd
d_long  in  1  instruction goes to a variable-latency unit
flush  in  1  branch/jump redirect; decode contents are killed this cycle
cmpl_valid  in  NUM_CMPL  per-channel completion strobe
cmpl_rd  in  NUM_CMPL*REG_AW  per-channel completed rd, channel i at bits [i*REG_AW +: REG_AW]
stall_d  out  1  hold PC/F_D/D_E, insert bubble into E
busy_vec  out  NUM_REGS  registered scoreboard
outstanding  out  $clog2(MAX_OUTST+1)  registered count of set busy bits
cmpl_err  out  1  sticky: completion to a non-busy register
hazard_timeout  out  1  sticky: watchdog expired

Behaviour:
- Reset (async, rst_n=0): busy_vec=0, outstanding=0, cmpl_err=0, hazard_timeout=0, watchdog count=0. stall_d is 0 while in reset.
- clr_vec (comb): bit r is set if any cmpl_valid[i] has cmpl_rd[i]==r and busy_vec[r]=1. Duplicate channels on the same r produce a single clear.
- eff_busy = busy_vec & ~clr_vec. Completion bypass: a same-cycle completion resolves the hazard with zero added latency.
- raw: (d_rs1_used & d_rs1!=0 & eff_busy[d_rs1]) | (d_rs2_used & d_rs2!=0 & eff_busy[d_rs2]).
- waw: d_rd_we & d_rd!=0 & eff_busy[d_rd].
- cap: d_long & d_rd_we & d_rd!=0 & (outstanding - popcount(clr_vec) == MAX_OUTST).
- stall_d = d_valid & ~flush & (raw | waw | cap). This is combinational, and flush takes priority.
- fire = d_valid & ~flush & ~stall_d & d_long & d_rd_we & d_rd!=0.
- Next state: busy_vec <= (busy_vec & ~clr_vec) | (fire ? onehot(d_rd) : 0). Set wins over clear on the same bit. waw makes same-bit set and clear impossible unless the bypass cleared it first.
- outstanding <= outstanding - popcount(clr_vec) + fire. It always equals popcount(busy_vec). It never exceeds MAX_OUTST and never underflows.
- x0 is never set. A completion to x0 is ignored and does not raise cmpl_err.
- cmpl_err is set when any cmpl_valid[i] targets a nonzero rd that is not busy, or when two channels target the same rd in one cycle. It clears only on reset.
- flush does not touch the scoreboard. Ops already issued are older than the redirecting branch and must complete. A fire is suppressed in a flush cycle.
- Watchdog: the counter increments while stall_d=1 and resets to 0 when stall_d=0. When it reaches TIMEOUT-1 while stalled, hazard_timeout is set (sticky) and the counter saturates.
- Reset asserted mid-operation clears all in-flight state. Completions arriving after reset are then flagged via cmpl_err.

Test Plan:
1. Reset then idle -> busy_vec=0, outstanding=0, stall_d=0, both sticky flags 0.
2. Issue long op d_rd=5 (fire) -> next cycle busy_vec[5]=1, outstanding=1. A following op with d_rs1=5 used -> stall_d=1 each cycle. cmpl_valid[1]=1, cmpl_rd=5 -> stall_d=0 that same cycle; busy[5]=0 the next cycle.
3. Issue long ops to x1..x4 (MAX_OUTST=4) -> outstanding=4. A 5th long op to x6 -> stall_d=1. A completion of x2 in the same cycle -> no stall; x6 set, x2 cleared, outstanding stays 4.
4. Long op with d_rd=0, plus cmpl to x0 -> no busy bit, outstanding=0, cmpl_err=0. Cmpl to x9 while not busy -> cmpl_err=1, held until rst_n low.
5. busy[7]=1, decode reads x7 with flush=1 -> stall_d=0, no fire, busy[7] still 1. A two-channel completion of x7 in one cycle -> busy[7]=0, outstanding decrements by 1, cmpl_err=1.
6. TIMEOUT=8, hold a RAW stall 8 cycles -> hazard_timeout=1 on the 8th stalled cycle edge. Pulse rst_n low asynchronously mid-stall -> all outputs 0 immediately.
